// File: rtl/pulse_ce_xfer_if.sv
// Pulse transfer bundle between a pulse source/sink agent and pulse_ce_xfer.
// Latency: none (wiring only). Backpressure: none; ce_out paces the output side.
// Ports: pulse_in/ce_out/clr_ovf driven by master; pulse_out/pending/busy/ovf driven by slave.
interface pulse_ce_xfer_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 4
);
  logic [N_CH-1:0]       pulse_in;
  logic                  ce_out;
  logic [N_CH-1:0]       clr_ovf;
  logic [N_CH-1:0]       pulse_out;
  logic [N_CH*CNT_W-1:0] pending;
  logic [N_CH-1:0]       busy;
  logic [N_CH-1:0]       ovf;

  modport master (
    output pulse_in, ce_out, clr_ovf,
    input  pulse_out, pending, busy, ovf
  );

  modport slave (
    input  pulse_in, ce_out, clr_ovf,
    output pulse_out, pending, busy, ovf
  );
endinterface

// File: rtl/pulse_ce_xfer.sv
// Per-channel pulse accumulator re-emitting source pulses on destination enable strobes.
// Latency: pulse_in at t -> counter at t+1 -> earliest pulse_out at t+2 (if ce_out at t+1).
// Backpressure: none to the source; counters absorb events, saturate (MERGE=0) or merge (MERGE=1).
// Ports: clk, rst (sync, active-high); bus (slave modport) carries pulse_in, ce_out, clr_ovf
//        in and pulse_out, pending (packed counters), busy, ovf (sticky) out.
module pulse_ce_xfer #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 4,
  parameter int MERGE = 0
) (
  input  logic           clk,
  input  logic           rst,
  pulse_ce_xfer_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]      cnt_q [N_CH];
  logic [CNT_W-1:0]      cnt_d [N_CH];
  logic [N_CH-1:0]       dec;
  logic [N_CH-1:0]       ovf_set;
  logic [N_CH-1:0]       pulse_q;
  logic [N_CH-1:0]       ovf_q;
  logic [N_CH*CNT_W-1:0] pending_w;
  logic [N_CH-1:0]       busy_w;

  // Next-count logic. A decrement only happens against a nonzero registered
  // count, so the counter can never underflow.
  always_comb begin
    dec     = '0;
    ovf_set = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      dec[i]   = bus.ce_out && (cnt_q[i] != '0);
      if (MERGE != 0) begin
        // Merged mode: any new event leaves exactly one pending pulse, even
        // when the previous one is consumed in the same cycle.
        if (bus.pulse_in[i]) begin
          cnt_d[i] = CNT_ONE;
        end else if (dec[i]) begin
          cnt_d[i] = '0;
        end
      end else begin
        if (bus.pulse_in[i] && !dec[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            ovf_set[i] = 1'b1;  // event lost: hold count, flag it
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end else if (!bus.pulse_in[i] && dec[i]) begin
          cnt_d[i] = cnt_q[i] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
      pulse_q <= '0;
      ovf_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= dec;
      // A new overflow beats a simultaneous clear.
      ovf_q   <= ovf_set | (ovf_q & ~bus.clr_ovf);
    end
  end

  always_comb begin
    pending_w = '0;
    busy_w    = '0;
    for (int i = 0; i < N_CH; i++) begin
      pending_w[i*CNT_W +: CNT_W] = cnt_q[i];
      busy_w[i]                   = (cnt_q[i] != '0);
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.pending   = pending_w;
  assign bus.busy      = busy_w;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pulse_ce_xfer.sv
// Self-checking bench for pulse_ce_xfer: three instances (A: CNT_W=4 lossless,
// B: CNT_W=4 merged, C: CNT_W=8 lossless) share clk/rst; each scenario task
// drives one instance and checks it against expectations derived from the event rules.
module tb_pulse_ce_xfer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_ce_xfer_if #(.N_CH(4), .CNT_W(4)) ifa ();
  pulse_ce_xfer_if #(.N_CH(4), .CNT_W(4)) ifb ();
  pulse_ce_xfer_if #(.N_CH(4), .CNT_W(8)) ifc ();

  pulse_ce_xfer #(.N_CH(4), .CNT_W(4), .MERGE(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  pulse_ce_xfer #(.N_CH(4), .CNT_W(4), .MERGE(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  pulse_ce_xfer #(.N_CH(4), .CNT_W(8), .MERGE(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifa.pulse_in = '0; ifa.ce_out = 1'b0; ifa.clr_ovf = '0;
    ifb.pulse_in = '0; ifb.ce_out = 1'b0; ifb.clr_ovf = '0;
    ifc.pulse_in = '0; ifc.ce_out = 1'b0; ifc.clr_ovf = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    tick();
    tick();
    checks++;
    if ({ifa.pulse_out, ifa.pending, ifa.busy, ifa.ovf} !== 28'h0) begin
      errors++; $display("FAIL reset_a got %h exp 0", {ifa.pulse_out, ifa.pending, ifa.busy, ifa.ovf});
    end
    checks++;
    if ({ifb.pulse_out, ifb.pending, ifb.busy, ifb.ovf} !== 28'h0) begin
      errors++; $display("FAIL reset_b got %h exp 0", {ifb.pulse_out, ifb.pending, ifb.busy, ifb.ovf});
    end
    checks++;
    if ({ifc.pulse_out, ifc.pending, ifc.busy, ifc.ovf} !== 44'h0) begin
      errors++; $display("FAIL reset_c got %h exp 0", {ifc.pulse_out, ifc.pending, ifc.busy, ifc.ovf});
    end
    rst = 1'b0;
  endtask

  // ch0 pulse in iteration 1, strobe every 4th cycle (iterations 3,7,...):
  // the first strobe at or after iteration 2 is iteration 3, so the pulse
  // is observed right after that edge.
  task automatic test_single();
    int n = 0;
    int first = -1;
    for (int k = 0; k < 16; k++) begin
      ifa.pulse_in = (k == 1) ? 4'b0001 : 4'b0000;
      ifa.ce_out   = ((k % 4) == 3);
      tick();
      if (ifa.pulse_out[0] === 1'b1) begin
        n++;
        if (first < 0) first = k;
      end
      checks++;
      if (ifa.pulse_out[3:1] !== 3'b000) begin
        errors++; $display("FAIL single_other_ch k=%0d got %b exp 000", k, ifa.pulse_out[3:1]);
      end
    end
    idle_all();
    checks++;
    if (n != 1) begin errors++; $display("FAIL single_count got %0d exp 1", n); end
    checks++;
    if (first != 3) begin errors++; $display("FAIL single_time got %0d exp 3", first); end
    checks++;
    if (ifa.pending !== 16'h0) begin errors++; $display("FAIL single_pending got %h exp 0", ifa.pending); end
  endtask

  task automatic test_burst();
    int n = 0;
    int first = -1;
    int last = -1;
    for (int k = 0; k < 10; k++) begin
      ifa.pulse_in = 4'b0010;
      tick();
    end
    ifa.pulse_in = '0;
    tick();
    checks++;
    if (ifa.pending[7:4] !== 4'd10) begin errors++; $display("FAIL burst_pending got %0d exp 10", ifa.pending[7:4]); end
    checks++;
    if (ifa.busy !== 4'b0010) begin errors++; $display("FAIL burst_busy got %b exp 0010", ifa.busy); end
    ifa.ce_out = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (ifa.pulse_out[1] === 1'b1) begin
        n++;
        if (first < 0) first = j;
        last = j;
      end
    end
    ifa.ce_out = 1'b0;
    checks++;
    if (n != 10 || first != 0 || last != 9) begin
      errors++; $display("FAIL burst_drain got n=%0d first=%0d last=%0d exp n=10 first=0 last=9", n, first, last);
    end
    checks++;
    if (ifa.pending !== 16'h0 || ifa.busy !== 4'b0) begin
      errors++; $display("FAIL burst_empty got pending=%h busy=%b exp 0", ifa.pending, ifa.busy);
    end
  endtask

  task automatic test_saturation();
    int n = 0;
    for (int k = 0; k < 17; k++) begin
      ifa.pulse_in = 4'b0100;
      tick();
    end
    ifa.pulse_in = '0;
    checks++;
    if (ifa.pending[11:8] !== 4'd15) begin errors++; $display("FAIL sat_pending got %0d exp 15", ifa.pending[11:8]); end
    checks++;
    if (ifa.ovf !== 4'b0100) begin errors++; $display("FAIL sat_ovf got %b exp 0100", ifa.ovf); end
    ifa.ce_out = 1'b1;
    for (int j = 0; j < 18; j++) begin
      tick();
      if (ifa.pulse_out[2] === 1'b1) n++;
    end
    ifa.ce_out = 1'b0;
    checks++;
    if (n != 15) begin errors++; $display("FAIL sat_drain got %0d exp 15", n); end
    checks++;
    if (ifa.ovf !== 4'b0100) begin errors++; $display("FAIL sat_sticky got %b exp 0100", ifa.ovf); end
    ifa.clr_ovf = 4'b0100;
    tick();
    ifa.clr_ovf = '0;
    checks++;
    if (ifa.ovf !== 4'b0000) begin errors++; $display("FAIL sat_clear got %b exp 0000", ifa.ovf); end
    // refill to 15, then overflow and clear in the same cycle: set wins
    for (int k = 0; k < 15; k++) begin
      ifa.pulse_in = 4'b0100;
      tick();
    end
    ifa.clr_ovf = 4'b0100;
    tick();
    ifa.pulse_in = '0;
    ifa.clr_ovf  = '0;
    checks++;
    if (ifa.ovf !== 4'b0100) begin errors++; $display("FAIL sat_set_wins got %b exp 0100", ifa.ovf); end
    ifa.clr_ovf = 4'b0100;
    ifa.ce_out  = 1'b1;
    for (int j = 0; j < 16; j++) tick();
    idle_all();
  endtask

  task automatic test_simultaneous();
    ifa.pulse_in = 4'b1000;
    tick();
    ifa.ce_out = 1'b1;
    tick();
    checks++;
    if (ifa.pending[15:12] !== 4'd1 || ifa.pulse_out[3] !== 1'b1) begin
      errors++; $display("FAIL simul_same_cycle got cnt=%0d out=%b exp cnt=1 out=1", ifa.pending[15:12], ifa.pulse_out[3]);
    end
    ifa.pulse_in = '0;
    tick();
    checks++;
    if (ifa.pending[15:12] !== 4'd0 || ifa.pulse_out[3] !== 1'b1) begin
      errors++; $display("FAIL simul_second got cnt=%0d out=%b exp cnt=0 out=1", ifa.pending[15:12], ifa.pulse_out[3]);
    end
    ifa.ce_out = 1'b0;
    tick();
    checks++;
    if (ifa.pulse_out !== 4'b0) begin errors++; $display("FAIL simul_quiet got %b exp 0000", ifa.pulse_out); end
  endtask

  task automatic test_merge();
    int n = 0;
    for (int k = 0; k < 5; k++) begin
      ifb.pulse_in = 4'b0001;
      tick();
    end
    ifb.pulse_in = '0;
    checks++;
    if (ifb.pending[3:0] !== 4'd1 || ifb.ovf !== 4'b0) begin
      errors++; $display("FAIL merge_hold got cnt=%0d ovf=%b exp cnt=1 ovf=0000", ifb.pending[3:0], ifb.ovf);
    end
    ifb.ce_out = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (ifb.pulse_out[0] === 1'b1) n++;
    end
    ifb.ce_out = 1'b0;
    checks++;
    if (n != 1) begin errors++; $display("FAIL merge_count got %0d exp 1", n); end
    ifb.pulse_in = 4'b0001;
    tick();
    ifb.ce_out = 1'b1;
    tick();
    checks++;
    if (ifb.pending[3:0] !== 4'd1 || ifb.pulse_out[0] !== 1'b1) begin
      errors++; $display("FAIL merge_simul got cnt=%0d out=%b exp cnt=1 out=1", ifb.pending[3:0], ifb.pulse_out[0]);
    end
    ifb.pulse_in = '0;
    tick();
    checks++;
    if (ifb.pending[3:0] !== 4'd0 || ifb.pulse_out[0] !== 1'b1) begin
      errors++; $display("FAIL merge_retain got cnt=%0d out=%b exp cnt=0 out=1", ifb.pending[3:0], ifb.pulse_out[0]);
    end
    idle_all();
    tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 7; k++) begin
      ifa.pulse_in = 4'b0001;
      tick();
    end
    ifa.pulse_in = '0;
    checks++;
    if (ifa.pending[3:0] !== 4'd7) begin errors++; $display("FAIL rstmid_pending got %0d exp 7", ifa.pending[3:0]); end
    ifa.ce_out   = 1'b1;
    ifa.pulse_in = 4'b1111;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifa.pulse_in = '0;
    checks++;
    if ({ifa.pulse_out, ifa.pending, ifa.busy, ifa.ovf} !== 28'h0) begin
      errors++; $display("FAIL rstmid_outputs got %h exp 0", {ifa.pulse_out, ifa.pending, ifa.busy, ifa.ovf});
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++;
      if (ifa.pulse_out !== 4'b0) begin errors++; $display("FAIL rstmid_no_out j=%0d got %b exp 0000", j, ifa.pulse_out); end
    end
    ifa.ce_out = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifa.pulse_in = 4'b0001;
    tick();
    ifa.pulse_in = '0;
    checks++;
    if (ifa.pending[3:0] !== 4'd1) begin errors++; $display("FAIL rst_first_cycle got %0d exp 1", ifa.pending[3:0]); end
    ifa.ce_out = 1'b1;
    tick();
    checks++;
    if (ifa.pulse_out !== 4'b0001) begin errors++; $display("FAIL rst_first_drain got %b exp 0001", ifa.pulse_out); end
    idle_all();
    tick();
  endtask

  // Reference: each channel is an integer count of accepted-but-unsent events.
  // A strobe emits one event next cycle when the count is positive.
  task automatic test_random();
    int pend [4];
    int n_in [4];
    int n_out [4];
    logic [3:0] pi;
    logic [3:0] exp_po;
    logic [31:0] exp_pend;
    logic ce;
    for (int c = 0; c < 4; c++) begin pend[c] = 0; n_in[c] = 0; n_out[c] = 0; end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int c = 0; c < 4; c++) pi[c] = ($urandom_range(9) < 3);
      ce = 1'($urandom_range(1));
      ifc.pulse_in = pi;
      ifc.ce_out   = ce;
      for (int c = 0; c < 4; c++) begin
        exp_po[c] = ce && (pend[c] > 0);
        pend[c] = pend[c] + int'(pi[c]) - int'(exp_po[c]);
        if (pend[c] > 255) pend[c] = 255;
        n_in[c] += int'(pi[c]);
        exp_pend[c*8 +: 8] = 8'(pend[c]);
      end
      tick();
      for (int c = 0; c < 4; c++) n_out[c] += int'(ifc.pulse_out[c] === 1'b1);
      checks++;
      if (ifc.pulse_out !== exp_po || ifc.pending !== exp_pend) begin
        errors++; $display("FAIL rand_cycle %0d got out=%b pend=%h exp out=%b pend=%h",
                           cyc, ifc.pulse_out, ifc.pending, exp_po, exp_pend);
      end
    end
    ifc.pulse_in = '0;
    ifc.ce_out   = 1'b1;
    for (int j = 0; j < 300; j++) begin
      tick();
      for (int c = 0; c < 4; c++) n_out[c] += int'(ifc.pulse_out[c] === 1'b1);
    end
    ifc.ce_out = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (n_in[c] != n_out[c]) begin
        errors++; $display("FAIL rand_conserve ch%0d got out=%0d exp in=%0d", c, n_out[c], n_in[c]);
      end
    end
    checks++;
    if (ifc.ovf !== 4'b0 || ifc.pending !== 32'h0) begin
      errors++; $display("FAIL rand_final got ovf=%b pend=%h exp 0", ifc.ovf, ifc.pending);
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_single();
    test_burst();
    test_saturation();
    test_simultaneous();
    test_merge();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
